// File: rtl/bus_arbiter.sv
// Hands the MID/SID/AMID bus-select fields to a DMA requester for a bounded burst, starting only at an instruction boundary.
// DRAIN/RELEASE turnaround cycles keep both enables low so the data bus never has two drivers.
module bus_arbiter #(
    parameter int BURST_MAX = 8,
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 instr_boundary,
    input  logic                 dma_req,
    input  logic                 dma_done,
    input  logic [4:0]           cpu_mid,
    input  logic [4:0]           cpu_sid,
    input  logic [1:0]           cpu_amid,
    input  logic                 cpu_en,
    input  logic [4:0]           dma_mid,
    input  logic [4:0]           dma_sid,
    input  logic [1:0]           dma_amid,
    input  logic                 dma_en,
    output logic [4:0]           mid,
    output logic [4:0]           sid,
    output logic [1:0]           amid,
    output logic                 mid_en,
    output logic                 sid_en,
    output logic                 cpu_hold,
    output logic                 dma_grant,
    output logic [CNT_WIDTH-1:0] burst_cnt
);

    localparam logic [1:0] CPU_OWN = 2'd0;
    localparam logic [1:0] DRAIN   = 2'd1;
    localparam logic [1:0] DMA_OWN = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(BURST_MAX);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       cpu_served;
    logic       dma_exit;

    assign dma_exit = dma_done | ~dma_req | (burst_cnt == CNT_MAX);

    always_comb begin
        state_nxt = state;
        case (state)
            CPU_OWN: if (dma_req && instr_boundary && cpu_served) state_nxt = DRAIN;
            DRAIN:   state_nxt = DMA_OWN;
            DMA_OWN: if (dma_exit) state_nxt = RELEASE;
            default: state_nxt = CPU_OWN;
        endcase
    end

    // cpu_hold and dma_grant are registered copies of the next-state decode.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= CPU_OWN;
            cpu_served <= 1'b1;
            cpu_hold   <= 1'b0;
            dma_grant  <= 1'b0;
            burst_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            cpu_hold  <= (state_nxt != CPU_OWN);
            dma_grant <= (state_nxt == DMA_OWN);
            case (state)
                CPU_OWN: begin
                    burst_cnt <= '0;
                    if (instr_boundary) cpu_served <= 1'b1;
                end
                DRAIN:   burst_cnt <= CNT_WIDTH'(1);
                DMA_OWN: if (!dma_exit) burst_cnt <= burst_cnt + 1'b1;
                default: begin
                    burst_cnt  <= '0;
                    cpu_served <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        mid    = 5'd0;
        sid    = 5'd0;
        amid   = cpu_amid;
        mid_en = 1'b0;
        sid_en = 1'b0;
        case (state)
            CPU_OWN: begin
                mid    = cpu_mid;
                sid    = cpu_sid;
                mid_en = cpu_en;
                sid_en = cpu_en;
            end
            DMA_OWN: begin
                mid    = dma_mid;
                sid    = dma_sid;
                amid   = dma_amid;
                mid_en = dma_en;
                sid_en = dma_en;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: reset, full burst, early done, withdrawn request,
// fairness gap, bus isolation, reset mid-burst and done coinciding with BURST_MAX.
module tb_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       instr_boundary, dma_req, dma_done;
    logic [4:0] cpu_mid, cpu_sid, dma_mid, dma_sid;
    logic [1:0] cpu_amid, dma_amid;
    logic       cpu_en, dma_en;
    logic [4:0] mid, sid;
    logic [1:0] amid;
    logic       mid_en, sid_en, cpu_hold, dma_grant;
    logic [3:0] burst_cnt;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.BURST_MAX(8), .CNT_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .instr_boundary(instr_boundary),
        .dma_req(dma_req), .dma_done(dma_done),
        .cpu_mid(cpu_mid), .cpu_sid(cpu_sid), .cpu_amid(cpu_amid), .cpu_en(cpu_en),
        .dma_mid(dma_mid), .dma_sid(dma_sid), .dma_amid(dma_amid), .dma_en(dma_en),
        .mid(mid), .sid(sid), .amid(amid), .mid_en(mid_en), .sid_en(sid_en),
        .cpu_hold(cpu_hold), .dma_grant(dma_grant), .burst_cnt(burst_cnt)
    );

    // Observed tuple: {cpu_hold, dma_grant, burst_cnt, mid_en, sid_en, amid, mid, sid}
    logic [19:0] obs;
    assign obs = {cpu_hold, dma_grant, burst_cnt, mid_en, sid_en, amid, mid, sid};

    function automatic logic [19:0] e_cpu();
        return {1'b0, 1'b0, 4'd0, cpu_en, cpu_en, cpu_amid, cpu_mid, cpu_sid};
    endfunction
    function automatic logic [19:0] e_drain();
        return {1'b1, 1'b0, 4'd0, 1'b0, 1'b0, cpu_amid, 5'd0, 5'd0};
    endfunction
    function automatic logic [19:0] e_dma(input logic [3:0] k);
        return {1'b1, 1'b1, k, dma_en, dma_en, dma_amid, dma_mid, dma_sid};
    endfunction
    function automatic logic [19:0] e_rel(input logic [3:0] k);
        return {1'b1, 1'b0, k, 1'b0, 1'b0, cpu_amid, 5'd0, 5'd0};
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b0; dma_req = 1'b1; instr_boundary = 1'b1; dma_done = 1'b0;
        step(); step();
        nvec++;
        if (obs !== e_cpu()) begin
            nerr++; $display("FAIL reset_state: got %h expected %h", obs, e_cpu());
        end
        reset = 1'b1; dma_req = 1'b0; instr_boundary = 1'b0;
        step();
        nvec++;
        if (obs !== e_cpu()) begin
            nerr++; $display("FAIL reset_release_idle: got %h expected %h", obs, e_cpu());
        end
    endtask

    task automatic test_full_burst();
        dma_req = 1'b1; instr_boundary = 1'b1;
        step();
        nvec++;
        if (obs !== e_drain()) begin
            nerr++; $display("FAIL full_drain: got %h expected %h", obs, e_drain());
        end
        instr_boundary = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            nvec++;
            if (obs !== e_dma(4'(k))) begin
                nerr++; $display("FAIL full_dma%0d: got %h expected %h", k, obs, e_dma(4'(k)));
            end
        end
        step();
        nvec++;
        if (obs !== e_rel(4'd8)) begin
            nerr++; $display("FAIL full_release: got %h expected %h", obs, e_rel(4'd8));
        end
        step();
        nvec++;
        if (obs !== e_cpu()) begin
            nerr++; $display("FAIL full_back_to_cpu: got %h expected %h", obs, e_cpu());
        end
        dma_req = 1'b0;
    endtask

    // Request raised then dropped before a boundary; the boundary that follows
    // must not grant but does mark the CPU as served.
    task automatic test_withdrawn_req();
        dma_req = 1'b1;
        step(); step();
        nvec++;
        if (obs !== e_cpu()) begin
            nerr++; $display("FAIL withdrawn_pending: got %h expected %h", obs, e_cpu());
        end
        dma_req = 1'b0; instr_boundary = 1'b1;
        step();
        nvec++;
        if (obs !== e_cpu()) begin
            nerr++; $display("FAIL withdrawn_no_grant: got %h expected %h", obs, e_cpu());
        end
        instr_boundary = 1'b0;
    endtask

    task automatic test_early_done();
        dma_req = 1'b1; instr_boundary = 1'b1;
        step();
        nvec++;
        if (obs !== e_drain()) begin
            nerr++; $display("FAIL early_drain: got %h expected %h", obs, e_drain());
        end
        instr_boundary = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            nvec++;
            if (obs !== e_dma(4'(k))) begin
                nerr++; $display("FAIL early_dma%0d: got %h expected %h", k, obs, e_dma(4'(k)));
            end
        end
        dma_done = 1'b1;
        step();
        dma_done = 1'b0;
        nvec++;
        if (obs !== e_rel(4'd3)) begin
            nerr++; $display("FAIL early_release: got %h expected %h", obs, e_rel(4'd3));
        end
        step();
        nvec++;
        if (obs !== e_cpu()) begin
            nerr++; $display("FAIL early_back_to_cpu: got %h expected %h", obs, e_cpu());
        end
    endtask

    // dma_req stays high from the previous burst; first boundary only serves the CPU.
    task automatic test_fairness_and_reset_mid_burst();
        instr_boundary = 1'b1;
        step();
        nvec++;
        if (obs !== e_cpu()) begin
            nerr++; $display("FAIL fair_first_boundary: got %h expected %h", obs, e_cpu());
        end
        instr_boundary = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            nvec++;
            if (obs !== e_cpu()) begin
                nerr++; $display("FAIL fair_instr_cycle%0d: got %h expected %h", k, obs, e_cpu());
            end
        end
        instr_boundary = 1'b1;
        step();
        nvec++;
        if (obs !== e_drain()) begin
            nerr++; $display("FAIL fair_second_grant: got %h expected %h", obs, e_drain());
        end
        instr_boundary = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            nvec++;
            if (obs !== e_dma(4'(k))) begin
                nerr++; $display("FAIL midrst_dma%0d: got %h expected %h", k, obs, e_dma(4'(k)));
            end
        end
        reset = 1'b0;
        step();
        nvec++;
        if (obs !== e_cpu()) begin
            nerr++; $display("FAIL midrst_cpu: got %h expected %h", obs, e_cpu());
        end
        reset = 1'b1; instr_boundary = 1'b1;
        step();
        nvec++;
        if (obs !== e_drain()) begin
            nerr++; $display("FAIL midrst_regrant: got %h expected %h", obs, e_drain());
        end
        instr_boundary = 1'b0;
        step();
        nvec++;
        if (obs !== e_dma(4'd1)) begin
            nerr++; $display("FAIL midrst_dma_again: got %h expected %h", obs, e_dma(4'd1));
        end
        dma_req = 1'b0;
        step();
        nvec++;
        if (obs !== e_rel(4'd1)) begin
            nerr++; $display("FAIL withdraw_release: got %h expected %h", obs, e_rel(4'd1));
        end
        step();
        nvec++;
        if (obs !== e_cpu()) begin
            nerr++; $display("FAIL withdraw_back_to_cpu: got %h expected %h", obs, e_cpu());
        end
    endtask

    task automatic test_done_at_max();
        instr_boundary = 1'b1;
        step();
        dma_req = 1'b1;
        step();
        nvec++;
        if (obs !== e_drain()) begin
            nerr++; $display("FAIL max_drain: got %h expected %h", obs, e_drain());
        end
        instr_boundary = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            nvec++;
            if (obs !== e_dma(4'(k))) begin
                nerr++; $display("FAIL max_dma%0d: got %h expected %h", k, obs, e_dma(4'(k)));
            end
        end
        dma_done = 1'b1;
        step();
        dma_done = 1'b0; dma_req = 1'b0;
        nvec++;
        if (obs !== e_rel(4'd8)) begin
            nerr++; $display("FAIL max_release: got %h expected %h", obs, e_rel(4'd8));
        end
        step();
        nvec++;
        if (obs !== e_cpu()) begin
            nerr++; $display("FAIL max_back_to_cpu: got %h expected %h", obs, e_cpu());
        end
    endtask

    initial begin
        cpu_mid = 5'h0A; cpu_sid = 5'h03; cpu_amid = 2'd1; cpu_en = 1'b1;
        dma_mid = 5'h15; dma_sid = 5'h1C; dma_amid = 2'd2; dma_en = 1'b1;
        test_reset();
        test_full_burst();
        test_withdrawn_req();
        test_early_done();
        test_fairness_and_reset_mid_burst();
        test_done_at_max();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Arbitrates ownership of the CPU's shared data bus and address bus between the control unit and one external DMA-style requester. The arbiter freezes the instruction timer only at an instruction boundary. It then hands the MID/SID/AMID bus-select fields to the requester for a bounded burst and returns them to the control unit. It sits between the control unit's control-bus outputs and the datapath decoders (MID, SID and AMID decoders).

## Interface
- BURST_MAX, 8: maximum number of DMA_OWN cycles per grant. Legal range is 1..2^CNT_WIDTH-1.
- CNT_WIDTH, 4: width of the burst counter.

- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset.
- instr_boundary  in  1  high for the cycle in which the instruction timer is at T0.
- dma_req  in  1  level request from the requester; held until granted or withdrawn.
- dma_done  in  1  requester ends its burst early; sampled only in DMA_OWN.
- cpu_mid, cpu_sid  in  5 each  control-unit master/slave IDs.
- cpu_amid  in  2  control-unit address master ID.
- cpu_en  in  1  control-unit MID_EN/SID_EN.
- dma_mid, dma_sid  in  5 each  requester master/slave IDs.
- dma_amid  in  2  requester address master ID.
- dma_en  in  1  requester bus enable.
- mid, sid  out  5 each  muxed IDs to the datapath decoders.
- amid  out  2  muxed address master ID.
- mid_en, sid_en  out  1 each  muxed enables.
- cpu_hold  out  1  drives the control-bus HLT field; freezes the timer.
- dma_grant  out  1  requester owns the buses.
- burst_cnt  out  CNT_WIDTH  number of DMA_OWN cycles used in the current grant.

## Operation
- FSM states: CPU_OWN, DRAIN, DMA_OWN, RELEASE. State is encoded in registers.
- Fairness flag cpu_served:
  - Cleared when the FSM enters CPU_OWN from RELEASE.
  - Set by the first instr_boundary seen in CPU_OWN.
  - A grant needs cpu_served=1 at the moment instr_boundary is sampled. The CPU therefore always completes at least one full instruction between bursts.
- CPU_OWN:
  - Outputs follow cpu_* fields; mid_en = sid_en = cpu_en.
  - Go to DRAIN if dma_req & instr_boundary & cpu_served.
- DRAIN (1 cycle):
  - cpu_hold = 1; mid_en = sid_en = 0; amid = cpu_amid; mid and sid are don't-care, driven 0.
  - Always go to DMA_OWN.
- DMA_OWN:
  - cpu_hold = 1, dma_grant = 1.
  - Outputs follow dma_* fields; mid_en = sid_en = dma_en.
  - burst_cnt increments by 1 per cycle, starting at 1 in the first DMA_OWN cycle.
  - Exit to RELEASE when any of: dma_done, ~dma_req, or burst_cnt == BURST_MAX.
- RELEASE (1 cycle):
  - cpu_hold = 1, dma_grant = 0; enables 0, amid = cpu_amid; burst_cnt holds its value.
  - Go to CPU_OWN.
  - burst_cnt clears to 0 on entry to CPU_OWN.
- dma_req withdrawn before a grant: no effect; the FSM stays in CPU_OWN.
- Simultaneous dma_done and count reaching BURST_MAX: single exit to RELEASE; no extra cycle.
- Reset (reset=0 at a rising edge, any state, including mid-burst):
  - state = CPU_OWN, cpu_served = 1, cpu_hold = 0, dma_grant = 0, burst_cnt = 0.
  - Outputs follow cpu_* fields from the next cycle.
- Turnaround cycles (DRAIN and RELEASE) never assert mid_en or sid_en. This guarantees no two drivers on data_bus.

## Timing
- cpu_hold, dma_grant and burst_cnt are registered.
- The mid, sid, amid and enable outputs are a combinational mux on the registered state, plus the current-cycle cpu_*/dma_* inputs.
- Grant latency:
  - instr_boundary is sampled at edge N, so DRAIN occupies cycle N+1 and cpu_hold is high from N+1.
  - dma_grant is high from N+2.
- Release latency: the exit condition is sampled at edge M; RELEASE occupies cycle M+1; cpu_hold falls and CPU_OWN begins at M+2.
- Burst length:
  - Maximum bus ownership = BURST_MAX cycles.
  - Maximum CPU stall per grant = BURST_MAX + 2 cycles.
- Back-to-back bursts with a persistent request: the minimum gap equals one full CPU instruction, because the next grant comes at the second instr_boundary after RELEASE.

## Test plan
- Reset: hold reset=0 for 2 cycles, driving dma_req=1 and instr_boundary=1 -> cpu_hold=0, dma_grant=0, burst_cnt=0; outputs equal cpu_* inputs.
- Full burst: BURST_MAX=8; dma_req=1 from T0 at edge N, dma_done=0 -> DRAIN at N+1; grant for cycles N+2..N+9 with burst_cnt 1..8; RELEASE at N+10; cpu_hold=0 at N+11.
- Early done: dma_done=1 in the 3rd DMA_OWN cycle -> exactly 3 grant cycles, burst_cnt=3 in RELEASE, then 0 in CPU_OWN.
- Fairness: dma_req held high continuously -> the second grant is issued only at the second instr_boundary after RELEASE; the instruction between bursts completes unmodified.
- Bus isolation: drive cpu_en=1 and dma_en=1 throughout -> mid_en=sid_en=0 in every DRAIN and RELEASE cycle; mid/sid equal dma_* only while dma_grant=1.
- Reset mid-burst: reset=0 in the 4th DMA_OWN cycle -> the next cycle is CPU_OWN with dma_grant=0, cpu_hold=0, burst_cnt=0; a new grant is possible at the first following instr_boundary.
